// File: rtl/life_gen_sequencer.sv
// Generation sequencer for a Game of Life cell grid: load, run/pause/step pacing, generation limit.
// Optional still-life auto-halt is compiled in with `define LIFE_AUTO_HALT_EN (adds port grid_changed).
module life_gen_sequencer #(
    parameter int PERIOD      = 4,
    parameter int LOAD_CYCLES = 2,
    parameter int GEN_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_load,
    input  logic             cmd_run,
    input  logic             cmd_step,
    input  logic             cmd_stop,
    input  logic [GEN_W-1:0] gen_limit,
`ifdef LIFE_AUTO_HALT_EN
    input  logic             grid_changed,
`endif
    output logic             grid_load,
    output logic             grid_ena,
    output logic [GEN_W-1:0] gen_count,
    output logic [2:0]       state,
    output logic             busy,
    output logic             done
);

    localparam int DIV_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int LD_W  = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PERIOD - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LOAD_CYCLES - 1);
    localparam logic [GEN_W-1:0] GEN_ONE  = GEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_PAUSED = 3'd2,
        S_RUN    = 3'd3,
        S_STEP   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [LD_W-1:0]   load_cnt_reg, load_cnt_next;
    logic [GEN_W-1:0]  gen_count_reg, gen_count_next;
    logic [GEN_W-1:0]  gen_inc;
    logic              grid_load_reg, grid_load_next;
    logic              grid_ena_reg, grid_ena_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              halt_hit;
`ifdef LIFE_AUTO_HALT_EN
    logic              ena_d_reg;
`endif

    assign gen_inc = gen_count_reg + GEN_ONE;

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        load_cnt_next  = load_cnt_reg;
        gen_count_next = gen_count_reg;
        halt_hit       = 1'b0;

        case (state_reg)
            S_IDLE: if (cmd_load) state_next = S_LOAD;
            S_LOAD: begin
                if (load_cnt_reg == LD_LAST) state_next = S_PAUSED;
                else                         load_cnt_next = load_cnt_reg + LD_W'(1);
            end
            S_PAUSED: begin
                if (cmd_stop)      state_next = S_PAUSED;
                else if (cmd_load) state_next = S_LOAD;
                else if (cmd_step) state_next = S_STEP;
                else if (cmd_run)  state_next = S_RUN;
            end
            S_RUN: begin
                if (cmd_stop)              state_next = S_PAUSED;
                else if (cmd_load)         state_next = S_LOAD;
                else if (div_reg == DIV_LAST) div_next = '0;
                else                       div_next = div_reg + DIV_W'(1);
            end
            S_STEP: state_next = S_PAUSED;
            S_HALT: if (cmd_load) state_next = S_LOAD;
            default: state_next = S_IDLE;
        endcase

        // The generation finishing at this edge is counted even if a command leaves RUN.
        if (grid_ena_reg) begin
            gen_count_next = gen_inc;
            if (gen_limit != '0 && gen_inc == gen_limit) halt_hit = 1'b1;
        end
`ifdef LIFE_AUTO_HALT_EN
        if (ena_d_reg && !grid_changed && (state_reg == S_RUN || state_reg == S_PAUSED))
            halt_hit = 1'b1;
`endif
        if (halt_hit) state_next = S_HALT;

        if (state_next == S_LOAD && state_reg != S_LOAD) begin
            gen_count_next = '0;
            load_cnt_next  = '0;
        end
        // Leaving RUN (or entering it from PAUSED) restarts the divider at zero.
        if (state_next != S_RUN || state_reg != S_RUN) div_next = '0;

        grid_load_next = (state_next == S_LOAD);
        grid_ena_next  = (state_next == S_STEP) || (state_next == S_RUN && div_next == DIV_LAST);
        busy_next      = (state_next == S_LOAD) || (state_next == S_RUN) || (state_next == S_STEP);
        done_next      = halt_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            div_reg       <= '0;
            load_cnt_reg  <= '0;
            gen_count_reg <= '0;
            grid_load_reg <= 1'b0;
            grid_ena_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef LIFE_AUTO_HALT_EN
            ena_d_reg     <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            load_cnt_reg  <= load_cnt_next;
            gen_count_reg <= gen_count_next;
            grid_load_reg <= grid_load_next;
            grid_ena_reg  <= grid_ena_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef LIFE_AUTO_HALT_EN
            ena_d_reg     <= grid_ena_reg;
`endif
        end
    end

    assign state     = state_reg;
    assign grid_load = grid_load_reg;
    assign grid_ena  = grid_ena_reg;
    assign gen_count = gen_count_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: doc/life_gen_sequencer.md
Name: life_gen_sequencer

Overview:
Controller that sequences a Game of Life cell array.
- Drives the array's load select (cells take their initial state) and a one-cycle generation-enable strobe.
- Paces generations with a programmable divider and supports run, pause, single-step and a generation limit.
- Sits between top-level control (buttons or host) and the cell grid; one instance per grid.

Parameters:
PERIOD, 4, clock cycles per generation in RUN (>=1; 1 = strobe every cycle)
LOAD_CYCLES, 2, cycles grid_load is held during a load (>=1)
GEN_W, 16, width of the generation counter and limit

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_load  in  1  pulse: load initial pattern into grid
cmd_run  in  1  pulse: free-run generations
cmd_step  in  1  pulse: advance exactly one generation
cmd_stop  in  1  pulse: pause
gen_limit  in  GEN_W  halt after this many generations since load; 0 = unlimited; sampled at each strobe
grid_load  out  1  high = cells select initial state
grid_ena  out  1  one-cycle generation strobe to cells
gen_count  out  GEN_W  generations completed since last load
state  out  3  FSM state: IDLE=0, LOAD=1, PAUSED=2, RUN=3, STEP=4, HALT=5
busy  out  1  high in LOAD, RUN, STEP
done  out  1  one-cycle pulse on limit reached
grid_changed  in  1  present only with LIFE_AUTO_HALT_EN; grid reports any cell changed in the last generation

Behaviour:
- All outputs registered. On rst low, asynchronously force state=IDLE, grid_load=0, grid_ena=0, gen_count=0, busy=0, done=0, and clear the divider.
- Command priority when several are high in one cycle: stop > load > step > run. Commands not legal in the current state are ignored with no side effect.
- IDLE: only cmd_load is accepted -> LOAD.
- LOAD:
  - grid_load=1 for exactly LOAD_CYCLES cycles; gen_count cleared on entry.
  - Then -> PAUSED.
  - All commands are ignored during LOAD, including cmd_stop and a repeated cmd_load.
- PAUSED:
  - cmd_load -> LOAD.
  - cmd_step -> STEP.
  - cmd_run -> RUN, with the divider cleared.
  - cmd_stop: no effect.
- STEP: lasts exactly one cycle with grid_ena=1, then -> PAUSED, or -> HALT if the limit is hit.
- RUN:
  - Divider counts 0..PERIOD-1 and wraps.
  - grid_ena=1 exactly in the cycle the divider equals PERIOD-1.
  - First strobe appears PERIOD cycles after the cycle cmd_run was sampled.
  - cmd_stop -> PAUSED; a strobe already high in that cycle still counts.
  - cmd_load -> LOAD.
  - cmd_step: ignored.
- Generation accounting:
  - At the clock edge ending each grid_ena cycle, gen_count increments. It wraps modulo 2^GEN_W when gen_limit=0.
  - If gen_limit!=0 and gen_count+1==gen_limit at that edge: -> HALT and done=1 for one cycle. gen_count then holds gen_limit.
  - If gen_limit is changed to a value <= gen_count while running, no halt occurs until wrap-around reaches equality.
- HALT:
  - grid_ena=0.
  - Only cmd_load is accepted -> LOAD; all others are ignored.
- grid_load and grid_ena are never high in the same cycle.
- Reset asserted mid-LOAD or mid-RUN aborts immediately to IDLE. gen_count is lost.

Optional Feature:
LIFE_AUTO_HALT_EN
- Defined:
  - Port grid_changed exists.
  - grid_changed is sampled in the cycle after each grid_ena strobe.
  - If it is 0 (still life reached), the FSM goes RUN/PAUSED -> HALT with a one-cycle done pulse.
  - Generation-limit halt and still-life halt in the same cycle produce a single done pulse.
- Undefined: the port is absent and only the generation limit causes HALT.

Test Plan:
- PERIOD=4, LOAD_CYCLES=2. After reset, pulse cmd_load -> grid_load high for exactly 2 cycles, state 1->2, gen_count=0. cmd_run/cmd_step in IDLE beforehand are ignored.
- In PAUSED, pulse cmd_step three times with idle gaps -> three single-cycle grid_ena pulses, gen_count=3, state returns to 2 each time.
- cmd_run with gen_limit=0 for 20 cycles -> grid_ena at cycles 4, 8, 12, 16, 20 after the command. cmd_stop at cycle 10 -> PAUSED, gen_count=2, no further strobes.
- gen_limit=5, cmd_run -> exactly 5 strobes, done pulse once, state=5, gen_count=5. cmd_run/cmd_step in HALT are ignored; cmd_load returns to LOAD and clears gen_count.
- cmd_stop and cmd_load in the same cycle during RUN -> PAUSED (stop wins). cmd_step and cmd_run together in PAUSED -> STEP. Drop rst low mid-RUN -> all outputs 0 and IDLE asynchronously, before the next clk edge.
- With LIFE_AUTO_HALT_EN: run with grid_changed=1 for 3 generations, then 0 after generation 4 -> HALT, done pulse, gen_count=4.
